add_sub_serial: RTL and testbench

- Multi-cycle, digit-serial unsigned adder/subtractor for wide operands.
- Processes one 4-bit digit per cycle and carries or borrows between digits in a register.
- Accepts one operation per valid/ready handshake and returns the result on a valid/ready output handshake.
- Sits downstream of operand producers and upstream of result consumers. It is the sequencing, carry-chaining counterpart of the 4-bit combinational add/sub slice.

---
 rtl/add_sub_serial.sv | 104 ++++++++++
 tb/tb_add_sub_serial.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/add_sub_serial.sv
// Digit-serial unsigned adder/subtractor: one 4-bit digit per cycle, carry/borrow chained in a register.
// Optional saturation of the result is enabled by defining ADD_SUB_SERIAL_SAT_EN.
module add_sub_serial #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_ovf,
    output logic         busy
);
    localparam int NDIG = W / 4;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q, b_q, res_q, res_d, final_sum;
    logic            sub_q, cy_q;
    logic [IW-1:0]   idx_q;
    logic            out_valid_q, out_ovf_q;
    logic [W-1:0]    out_sum_q;
    logic [3:0]      dig_a, dig_b;
    logic [4:0]      dig_full;
    logic            last_dig;

    // Bit 4 of the 5-bit digit result is the carry (add) or borrow (sub, wraps negative).
    always_comb begin
        dig_a    = a_q[{idx_q, 2'b00} +: 4];
        dig_b    = b_q[{idx_q, 2'b00} +: 4];
        dig_full = sub_q ? ({1'b0, dig_a} - {1'b0, dig_b} - {4'b0, cy_q})
                         : ({1'b0, dig_a} + {1'b0, dig_b} + {4'b0, cy_q});
        res_d    = res_q;
        res_d[{idx_q, 2'b00} +: 4] = dig_full[3:0];
        last_dig = (idx_q == IW'(NDIG - 1));
`ifdef ADD_SUB_SERIAL_SAT_EN
        if (dig_full[4]) final_sum = sub_q ? '0 : '1;
        else             final_sum = res_d;
`else
        final_sum = res_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sub_q       <= 1'b0;
            cy_q        <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        sub_q   <= in_sub;
                        cy_q    <= 1'b0;
                        idx_q   <= '0;
                        res_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    cy_q  <= dig_full[4];
                    idx_q <= idx_q + 1'b1;
                    if (last_dig) begin
                        idx_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_sum_q   <= final_sum;
                        out_ovf_q   <= dig_full[4];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_add_sub_serial.sv
// Directed and random checks of add_sub_serial at W=16 (saturating expectations when ADD_SUB_SERIAL_SAT_EN is defined).
module tb_add_sub_serial;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic        busy;

    int tests = 0;
    int fails = 0;

    add_sub_serial #(.W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drives one operation and collects the result; no checking here.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub, input int stall,
                          output logic [15:0] s, output logic o, output int lat, output bit to);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_sub = ~sub;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 50);
        to = !out_valid;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
        end
        s = out_sum; o = out_ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tests++; if (out_sum !== 16'h0 || out_ovf !== 1'b0) begin fails++; $display("FAIL reset_result got %h/%b exp 0000/0", out_sum, out_ovf); end
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        logic [15:0] s; logic o; int lat; bit to;
        run_op(16'h1234, 16'h0FFF, 1'b0, 0, s, o, lat, to);
        tests++; if (to || lat != 4) begin fails++; $display("FAIL latency got %0d exp 4", lat); end
        tests++; if (s !== 16'h2233) begin fails++; $display("FAIL lat_sum got %h exp 2233", s); end
        tests++; if (o !== 1'b0) begin fails++; $display("FAIL lat_ovf got %b exp 0", o); end
    endtask

    task automatic test_add_ovf();
        logic [15:0] s; logic o; int lat; bit to;
        logic [15:0] exp_s;
`ifdef ADD_SUB_SERIAL_SAT_EN
        exp_s = 16'hFFFF;
`else
        exp_s = 16'h0000;
`endif
        run_op(16'hFFFF, 16'h0001, 1'b0, 1, s, o, lat, to);
        tests++; if (to || s !== exp_s) begin fails++; $display("FAIL add_ovf_sum got %h exp %h", s, exp_s); end
        tests++; if (o !== 1'b1) begin fails++; $display("FAIL add_ovf_flag got %b exp 1", o); end
    endtask

    task automatic test_sub_borrow();
        logic [15:0] va [3] = '{16'h0000, 16'h1000, 16'hABCD};
        logic [15:0] vb [3] = '{16'h0001, 16'h0001, 16'hABCD};
`ifdef ADD_SUB_SERIAL_SAT_EN
        logic [15:0] vs [3] = '{16'h0000, 16'h0FFF, 16'h0000};
`else
        logic [15:0] vs [3] = '{16'hFFFF, 16'h0FFF, 16'h0000};
`endif
        logic        vo [3] = '{1'b1, 1'b0, 1'b0};
        logic [15:0] s; logic o; int lat; bit to;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b1, i, s, o, lat, to);
            tests++; if (to || s !== vs[i]) begin fails++; $display("FAIL sub_sum[%0d] got %h exp %h", i, s, vs[i]); end
            tests++; if (o !== vo[i]) begin fails++; $display("FAIL sub_ovf[%0d] got %b exp %b", i, o, vo[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        in_a = 16'h0003; in_b = 16'h0004; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        tests++; if (!out_valid) begin fails++; $display("FAIL bp_timeout got 0 exp 1"); end
        in_a = 16'hFFFF; in_b = 16'hFFFF; in_sub = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || out_sum !== 16'h0007 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d] got v=%b s=%h o=%b r=%b exp v=1 s=0007 o=0 r=0", i, out_valid, out_sum, out_ovf, in_ready);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL bp_release got v=%b r=%b b=%b exp v=0 r=1 b=0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] s; logic o; int lat; bit to;
        bit seen = 0;
        in_a = 16'hFFFF; in_b = 16'h0001; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL abort_in_ready_low got %b exp 0", in_ready); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 16'h0) begin
            fails++; $display("FAIL abort_state got v=%b b=%b s=%h exp v=0 b=0 s=0000", out_valid, busy, out_sum);
        end
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_in_ready_high got %b exp 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        out_ready = 1'b0;
        tests++; if (seen) begin fails++; $display("FAIL abort_no_result got 1 exp 0"); end
        run_op(16'h0001, 16'h0001, 1'b0, 0, s, o, lat, to);
        tests++; if (to || s !== 16'h0002 || o !== 1'b0) begin fails++; $display("FAIL abort_next_op got %h/%b exp 0002/0", s, o); end
    endtask

    task automatic test_random();
        logic [15:0] a, b, s, es; logic sub, o, eo; int lat; bit to;
        logic [16:0] wide;
        for (int k = 0; k < 1000; k++) begin
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            if (k % 8 == 0) b = a;
            if (sub) begin
                wide = {1'b0, a} - {1'b0, b};
                eo = (a < b);
            end else begin
                wide = {1'b0, a} + {1'b0, b};
                eo = wide[16];
            end
            es = wide[15:0];
`ifdef ADD_SUB_SERIAL_SAT_EN
            if (eo) es = sub ? 16'h0000 : 16'hFFFF;
`endif
            run_op(a, b, sub, $urandom_range(0, 3), s, o, lat, to);
            tests++; if (to || s !== es || o !== eo) begin
                fails++; $display("FAIL rand[%0d] %h %s %h got %h/%b exp %h/%b", k, a, sub ? "-" : "+", b, s, o, es, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_add_ovf();
        test_sub_borrow();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
